// File: rtl/piano_pkg.sv
// Shared constants for the piano tone bank: key count, note indices,
// NCO phase increments and the arbiter state encoding.
package piano_pkg;

    localparam int NUM_KEYS = 13;
    localparam int PHASE_W  = 18;

    localparam logic [3:0] NOTE_C4  = 4'd0;
    localparam logic [3:0] NOTE_CS4 = 4'd1;
    localparam logic [3:0] NOTE_D4  = 4'd2;
    localparam logic [3:0] NOTE_DS4 = 4'd3;
    localparam logic [3:0] NOTE_E4  = 4'd4;
    localparam logic [3:0] NOTE_F4  = 4'd5;
    localparam logic [3:0] NOTE_FS4 = 4'd6;
    localparam logic [3:0] NOTE_G4  = 4'd7;
    localparam logic [3:0] NOTE_GS4 = 4'd8;
    localparam logic [3:0] NOTE_A4  = 4'd9;
    localparam logic [3:0] NOTE_AS4 = 4'd10;
    localparam logic [3:0] NOTE_B4  = 4'd11;
    localparam logic [3:0] NOTE_C5  = 4'd12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } pianoState_e;

    // NCO increment per note; anything out of range maps to silence.
    function automatic logic [PHASE_W-1:0] phaseLookup(input logic [3:0] idx);
        case (idx)
            NOTE_C4:  return 18'd93664;
            NOTE_CS4: return 18'd99230;
            NOTE_D4:  return 18'd105130;
            NOTE_DS4: return 18'd111385;
            NOTE_E4:  return 18'd118008;
            NOTE_F4:  return 18'd125024;
            NOTE_FS4: return 18'd132456;
            NOTE_G4:  return 18'd140336;
            NOTE_GS4: return 18'd148677;
            NOTE_A4:  return 18'd157520;
            NOTE_AS4: return 18'd166885;
            NOTE_B4:  return 18'd176809;
            NOTE_C5:  return 18'd187324;
            default:  return '0;
        endcase
    endfunction

    function automatic logic [3:0] lowestSet(input logic [NUM_KEYS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer on the raw active-low input, then a
// stability counter that accepts a new level after DEBOUNCE_CYCLES samples.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic keyN,
    output logic held,
    output logic pressEvt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          syncHeld;
    logic [CW-1:0] cnt;

    assign syncHeld = ~sync2;

    // Synchronizer resets to "released" so a key held through reset is
    // treated as a fresh press once it has been stable long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            held     <= 1'b0;
            pressEvt <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= keyN;
            sync2    <= sync1;
            pressEvt <= 1'b0;
            if (syncHeld == held) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                held     <= syncHeld;
                pressEvt <= syncHeld;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/piano_note_arbiter.sv
// Debounces the 13 piano keys and selects one sounding note (last press wins).
// Define PIANO_RELEASE_HOLD_EN to hold the last note for RELEASE_CYCLES after release.
module piano_note_arbiter
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int RELEASE_CYCLES  = 1200000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic                note_valid,
    output logic [3:0]          note_idx,
    output logic [PHASE_W-1:0]  phase_inc,
    output logic                note_change,
    output logic [1:0]          stateDbg
);

    // Both vectors are indexed by note (bit 0 = C4), not by key_n position.
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] pressEvt;
    logic [15:0]         heldPad;
    logic                curReleased;

    pianoState_e state;
    pianoState_e stateNext;
    logic [3:0]  idxNext;
    logic        validNext;
    logic        changeNext;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : gKey
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uDeb (
            .clk     (clk),
            .rst_n   (rst_n),
            .keyN    (key_n[NUM_KEYS-1-i]),
            .held    (held[i]),
            .pressEvt(pressEvt[i])
        );
    end

    assign heldPad     = {3'b000, held};
    assign curReleased = (state == PLAY) && !heldPad[note_idx];
    assign stateDbg    = state;

`ifdef PIANO_RELEASE_HOLD_EN
    localparam int RCW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    logic [RCW-1:0] relCnt;
    logic           relDone;

    assign relDone = (state == RELEASE) && (relCnt == RCW'(RELEASE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relCnt <= '0;
        end else if ((state == RELEASE) && (stateNext == RELEASE)) begin
            relCnt <= relCnt + 1'b1;
        end else begin
            relCnt <= '0;
        end
    end
`endif

    // A fresh press always takes priority, so a press landing in the same
    // cycle as the current note's release never produces a silent gap.
    always_comb begin
        stateNext  = state;
        idxNext    = note_idx;
        validNext  = note_valid;
        changeNext = 1'b0;
        if (|pressEvt) begin
            stateNext  = PLAY;
            idxNext    = lowestSet(pressEvt);
            validNext  = 1'b1;
            changeNext = 1'b1;
        end else if (curReleased) begin
            if (|held) begin
                idxNext    = lowestSet(held);
                changeNext = 1'b1;
            end else begin
`ifdef PIANO_RELEASE_HOLD_EN
                stateNext = RELEASE;
`else
                stateNext = IDLE;
                idxNext   = '0;
                validNext = 1'b0;
`endif
            end
        end
`ifdef PIANO_RELEASE_HOLD_EN
        else if (relDone) begin
            stateNext = IDLE;
            idxNext   = '0;
            validNext = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            note_valid  <= 1'b0;
            note_idx    <= '0;
            phase_inc   <= '0;
            note_change <= 1'b0;
        end else begin
            state       <= stateNext;
            note_valid  <= validNext;
            note_idx    <= idxNext;
            phase_inc   <= validNext ? phaseLookup(idxNext) : '0;
            note_change <= changeNext;
        end
    end

endmodule

// File: tb/tb_piano_note_arbiter.sv
// Randomized and directed bench for piano_note_arbiter against a cycle-level
// behavioural model (window-based debounce, rule-based note selection).
module tb_piano_note_arbiter;

    localparam int DEB = 4;
    localparam int REL = 8;
    localparam logic [12:0] ALL_UP = 13'h1FFF;

`ifdef PIANO_RELEASE_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [12:0] key_n;
    logic        note_valid;
    logic [3:0]  note_idx;
    logic [17:0] phase_inc;
    logic        note_change;
    logic [1:0]  state_dbg;

    int checks;
    int failures;

    // key_n bit of note n is 12-n
    int phase_tab[13] = '{93664, 99230, 105130, 111385, 118008, 125024, 132456,
                          140336, 148677, 157520, 166885, 176809, 187324};

    logic [23:0] exp_q[$];
    logic [12:0] hist_q[$];
    logic [12:0] deb_held;
    logic [12:0] deb_press;
    bit          sounding;
    bit          in_release;
    int          rel_age;
    int          cur;

    logic [12:0] keys;
    int          sel;
    int          dur;

    piano_note_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .RELEASE_CYCLES (REL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .note_valid (note_valid),
        .note_idx   (note_idx),
        .phase_inc  (phase_inc),
        .note_change(note_change),
        .stateDbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_note(input logic [12:0] v);
        for (int n = 0; n < 13; n++) begin
            if (v[n]) return n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        hist_q.delete();
        repeat (DEB + 2) hist_q.push_back(ALL_UP);
        deb_held   = '0;
        deb_press  = '0;
        sounding   = 1'b0;
        in_release = 1'b0;
        rel_age    = 0;
        cur        = 0;
    endtask

    // One clock edge of the reference: select from last cycle's debounced
    // view, then advance the debounce view with the new raw sample.
    task automatic model_step(input logic [12:0] raw);
        int          lo_press;
        int          lo_held;
        bit          change;
        logic [12:0] s;
        bit          all_diff;
        change   = 1'b0;
        lo_press = lowest_note(deb_press);
        lo_held  = lowest_note(deb_held);
        if (lo_press >= 0) begin
            cur        = lo_press;
            sounding   = 1'b1;
            in_release = 1'b0;
            change     = 1'b1;
        end else if (sounding && !in_release && !deb_held[cur]) begin
            if (lo_held >= 0) begin
                cur    = lo_held;
                change = 1'b1;
            end else if (HOLD_EN) begin
                in_release = 1'b1;
                rel_age    = 0;
            end else begin
                sounding = 1'b0;
            end
        end else if (in_release) begin
            rel_age++;
            if (rel_age >= REL) begin
                in_release = 1'b0;
                sounding   = 1'b0;
            end
        end
        exp_q.push_back({sounding, sounding ? 4'(cur) : 4'd0,
                         sounding ? 18'(phase_tab[cur]) : 18'd0, change});

        // raw reaches the debouncer two edges late; a level is accepted once
        // DEB consecutive delayed samples all disagree with the current one
        hist_q.push_back(raw);
        deb_press = '0;
        for (int n = 0; n < 13; n++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                s = hist_q[hist_q.size() - 3 - j];
                if (!s[12 - n] == deb_held[n]) all_diff = 1'b0;
            end
            if (all_diff) begin
                deb_held[n] = ~deb_held[n];
                if (deb_held[n]) deb_press[n] = 1'b1;
            end
        end
        while (hist_q.size() > DEB + 2) void'(hist_q.pop_front());
    endtask

    task automatic compare_outputs();
        logic [23:0] e;
        e = exp_q.pop_front();
        check_val("valid",  32'(note_valid),  32'(e[23]));
        check_val("idx",    32'(note_idx),    32'(e[22:19]));
        check_val("phase",  32'(phase_inc),   32'(e[18:1]));
        check_val("change", 32'(note_change), 32'(e[0]));
    endtask

    // driver: called at a negedge, returns at the next negedge after checking
    task automatic tick(input logic [12:0] k);
        key_n = k;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_step(k);
        end
        @(negedge clk);
        compare_outputs();
    endtask

    function automatic logic [12:0] key_of(input int note);
        logic [12:0] v;
        v = ALL_UP;
        v[12 - note] = 1'b0;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        key_n    = ALL_UP;
        keys     = ALL_UP;
        model_reset();
        #1;
        check_val("rst_valid",  32'(note_valid),  0);
        check_val("rst_idx",    32'(note_idx),    0);
        check_val("rst_phase",  32'(phase_inc),   0);
        check_val("rst_change", 32'(note_change), 0);
        @(negedge clk);
        repeat (2) tick(ALL_UP);
        rst_n = 1'b1;

        repeat (6) tick(ALL_UP);
        check_val("idle_valid", 32'(note_valid), 0);

        // 3-cycle glitch on C4 must be filtered
        repeat (3) tick(key_of(0));
        repeat (8) tick(ALL_UP);
        check_val("glitch_valid", 32'(note_valid), 0);

        repeat (6) tick(key_of(0));
        check_val("c4_early_valid", 32'(note_valid), 0);
        tick(key_of(0));
        check_val("c4_valid",  32'(note_valid),  1);
        check_val("c4_idx",    32'(note_idx),    0);
        check_val("c4_phase",  32'(phase_inc),   93664);
        check_val("c4_change", 32'(note_change), 1);
        tick(key_of(0));
        check_val("c4_change_once", 32'(note_change), 0);
        repeat (20) tick(ALL_UP);

        // E4 held, A4 added then removed
        repeat (10) tick(key_of(4));
        repeat (7) tick(key_of(4) & key_of(9));
        check_val("a4_idx",   32'(note_idx),  9);
        check_val("a4_phase", 32'(phase_inc), 157520);
        repeat (3) tick(key_of(4) & key_of(9));
        repeat (7) tick(key_of(4));
        check_val("e4_back_idx",    32'(note_idx),    4);
        check_val("e4_back_phase",  32'(phase_inc),   118008);
        check_val("e4_back_change", 32'(note_change), 1);
        repeat (20) tick(ALL_UP);

        // D4 and G4 accepted together: lowest index wins
        repeat (7) tick(key_of(2) & key_of(7));
        check_val("dg_idx",   32'(note_idx),  2);
        check_val("dg_phase", 32'(phase_inc), 105130);

        // release both, press B4 shortly after
        for (int t = 1; t <= 10; t++) begin
            tick((t < 4) ? ALL_UP : key_of(11));
            check_val("rel_valid", 32'(note_valid),
                      (t <= 6 || t == 10 || HOLD_EN) ? 32'd1 : 32'd0);
        end
        check_val("b4_idx",   32'(note_idx),  11);
        check_val("b4_phase", 32'(phase_inc), 176809);
        repeat (20) tick(ALL_UP);

        // asynchronous reset mid-note with C5 held throughout
        repeat (8) tick(key_of(12));
        check_val("c5_pre_valid", 32'(note_valid), 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_val("async_valid", 32'(note_valid), 0);
        check_val("async_idx",   32'(note_idx),   0);
        check_val("async_phase", 32'(phase_inc),  0);
        @(negedge clk);
        repeat (2) tick(key_of(12));
        rst_n = 1'b1;
        repeat (6) tick(key_of(12));
        check_val("c5_early_valid", 32'(note_valid), 0);
        tick(key_of(12));
        check_val("c5_idx",   32'(note_idx),  12);
        check_val("c5_phase", 32'(phase_inc), 187324);
        repeat (20) tick(ALL_UP);

        // random chords, glitches and releases
        keys = ALL_UP;
        repeat (90) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) keys[$urandom_range(0, 12)] ^= 1'b1;
            else if (sel < 8) keys = ALL_UP;
            else keys = 13'($urandom) | 13'($urandom);
            dur = $urandom_range(1, 14);
            repeat (dur) tick(keys);
        end
        repeat (20) tick(ALL_UP);
        check_val("final_valid", 32'(note_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
